// File: rtl/wm_phase_timer.sv
// -----------------------------------------------------------------------------
// wm_phase_timer
//   Timing stage for the washing-machine controller. Tracks the controller state
//   bus and, for each timed phase (WASH, RINSE, SPIN, DRAIN), counts a
//   programmable number of prescaled ticks. When the count runs out it emits a
//   single-cycle cycle_complete pulse. An open door freezes the count, and the
//   remaining tick count is exposed for a front-panel display.
//
// Ports
//   clk             in   1      system clock, rising edge
//   rst             in   1      asynchronous reset, active-low
//   state           in   3      controller state bus (encoding table below)
//   door_closed     in   1      1 = door closed; 0 freezes timing
//   cycle_complete  out  1      one-cycle pulse: current timed phase expired
//   busy            out  1      timed phase in progress (paused or not)
//   remaining       out  CNT_W  ticks left in current phase, 0 when untimed
//   illegal_state   out  1      sticky: state 3'b111 was observed
//
// Controller states
//   state   | meaning
//   000     | IDLE    untimed
//   001     | FILL    untimed
//   010     | WASH    timed, WASH_T ticks
//   011     | RINSE   timed, RINSE_T ticks
//   100     | SPIN    timed, SPIN_T ticks
//   101     | DRAIN   timed, DRAIN_T ticks
//   110     | END     untimed
//   111     | illegal treated as untimed, sets illegal_state
// -----------------------------------------------------------------------------
module wm_phase_timer #(
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 4,
  parameter int WASH_T   = 5,
  parameter int RINSE_T  = 4,
  parameter int SPIN_T   = 3,
  parameter int DRAIN_T  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       state,
  input  logic             door_closed,
  output logic             cycle_complete,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             illegal_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_FILL    = 3'b001,
    ST_WASH    = 3'b010,
    ST_RINSE   = 3'b011,
    ST_SPIN    = 3'b100,
    ST_DRAIN   = 3'b101,
    ST_END     = 3'b110,
    ST_ILLEGAL = 3'b111
  } ctrl_state_e;

  localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX  = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] D_WASH  = CNT_W'(WASH_T);
  localparam logic [CNT_W-1:0] D_RINSE = CNT_W'(RINSE_T);
  localparam logic [CNT_W-1:0] D_SPIN  = CNT_W'(SPIN_T);
  localparam logic [CNT_W-1:0] D_DRAIN = CNT_W'(DRAIN_T);

  ctrl_state_e      r_state_q;
  logic [PS_W-1:0]  r_prescaler;
  logic [CNT_W-1:0] r_remaining;
  logic             r_done;
  logic             r_cc;
  logic             r_illegal;

  logic [PS_W-1:0]  w_prescaler_nxt;
  logic [CNT_W-1:0] w_remaining_nxt;
  logic             w_done_nxt;
  logic             w_cc_nxt;
  logic             w_illegal_nxt;
  logic             w_change;
  logic             w_timed_q;
  logic             w_armed;
  logic             w_run;
  logic             w_expire;

  function automatic logic f_timed(input ctrl_state_e s);
    return (s == ST_WASH) || (s == ST_RINSE) || (s == ST_SPIN) || (s == ST_DRAIN);
  endfunction

  function automatic logic [CNT_W-1:0] f_dur(input ctrl_state_e s);
    case (s)
      ST_WASH:  return D_WASH;
      ST_RINSE: return D_RINSE;
      ST_SPIN:  return D_SPIN;
      ST_DRAIN: return D_DRAIN;
      default:  return '0;
    endcase
  endfunction

  always_comb begin
    w_prescaler_nxt = r_prescaler;
    w_remaining_nxt = r_remaining;
    w_done_nxt      = r_done;
    w_cc_nxt        = 1'b0;
    w_illegal_nxt   = r_illegal | (state == 3'b111);

    w_change  = (state != r_state_q);
    w_timed_q = f_timed(r_state_q);
    w_armed   = w_timed_q && !r_done && door_closed;
    w_run     = w_armed && (r_remaining != '0);
    w_expire  = w_armed && (r_remaining == '0);

    // A new phase on the bus overrides any tick or expiry of the old phase.
    if (w_change) begin
      w_remaining_nxt = f_dur(ctrl_state_e'(state));
      w_prescaler_nxt = '0;
      w_done_nxt      = 1'b0;
    end else if (w_run) begin
      if (r_prescaler == PS_MAX) begin
        w_prescaler_nxt = '0;
        w_remaining_nxt = r_remaining - CNT_W'(1);
      end else begin
        w_prescaler_nxt = r_prescaler + PS_W'(1);
      end
    end else if (w_expire) begin
      w_cc_nxt   = 1'b1;
      w_done_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q   <= ST_IDLE;
      r_prescaler <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_cc        <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state_q   <= ctrl_state_e'(state);
      r_prescaler <= w_prescaler_nxt;
      r_remaining <= w_remaining_nxt;
      r_done      <= w_done_nxt;
      r_cc        <= w_cc_nxt;
      r_illegal   <= w_illegal_nxt;
    end
  end

  assign cycle_complete = r_cc;
  assign busy           = w_timed_q && !r_done;
  assign remaining      = r_remaining;
  assign illegal_state  = r_illegal;

endmodule
